hazard_stall_ctrl: RTL and testbench

Pipeline hazard and structural-stall controller for the SAD-extended MIPS core. It watches the ID and EX stages and drives PC write enable, IF/ID hold and flush, and ID/EX flush. It detects load-use hazards, squashes on taken branches, blocks Hi/Lo readers while a multi-cycle mult/div is in flight, and spaces SAD instructions so the SAD stages are never double-occupied. Registers are limited to two busy counters and two saturating statistics counters; the control outputs are combinational.

---
 rtl/hazard_stall_ctrl_pkg.sv | 24 ++
 rtl/hazard_stall_ctrl_if.sv | 46 ++++
 rtl/hazard_stall_ctrl_busy_timer.sv | 29 ++
 rtl/hazard_stall_ctrl.sv | 98 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared core constants and control bundle for the hazard/stall controller.
// Holds the zero-register id, default latencies and the pipeline control struct.
package cpu_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DIV_LAT_DEF = 32;
    localparam int SAD_LAT_DEF = 4;

    typedef struct packed {
        logic PCWrite;
        logic IfIdWrite;
        logic IfIdFlush;
        logic IdExFlush;
    } ctrl_t;

    // Width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs of the stall controller.
// master is the pipeline side, slave is the controller.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IdRs;
    logic [4:0]       IdRt;
    logic             IdUseRs;
    logic             IdUseRt;
    logic             IdHiLoUse;
    logic             IdSad;
    logic             ExMemRead;
    logic             ExRegWrite;
    logic [4:0]       ExDst;
    logic             ExBranchTaken;
    logic             ExMultiStart;

    logic             PCWrite;
    logic             IfIdWrite;
    logic             IfIdFlush;
    logic             IdExFlush;
    logic             Busy;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output IdRs, IdRt, IdUseRs, IdUseRt,
        output IdHiLoUse, IdSad,
        output ExMemRead, ExRegWrite, ExDst,
        output ExBranchTaken, ExMultiStart,
        input  PCWrite, IfIdWrite,
        input  IfIdFlush, IdExFlush,
        input  Busy, StallCount, FlushCount
    );

    modport slave (
        input  IdRs, IdRt, IdUseRs, IdUseRt,
        input  IdHiLoUse, IdSad,
        input  ExMemRead, ExRegWrite, ExDst,
        input  ExBranchTaken, ExMultiStart,
        output PCWrite, IfIdWrite,
        output IfIdFlush, IdExFlush,
        output Busy, StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_stall_ctrl_busy_timer.sv
// Occupancy down-counter: loads LAT, counts down to zero, flags nonzero.
// A load while already counting restarts from LAT.
module busy_timer
    import cpu_pkg::*;
#(
    parameter int LAT = 1,
    localparam int W = cnt_width(LAT)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    output logic busy
);

    logic [W-1:0] cnt = '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use, branch-squash, Hi/Lo and SAD-spacing stall controller.
// Control outputs are combinational from inputs and busy-counter state.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int SAD_LAT = SAD_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input logic          Clk,
    input logic          Reset,
    hazard_stall_ctrl_if.slave hz
);

    logic load_use;
    logic rs_hit;
    logic rt_hit;
    logic div_haz;
    logic sad_haz;
    logic stall;
    logic sad_issue;
    logic div_busy;
    logic sad_busy;
    ctrl_t ctrl;

    logic [CNT_W-1:0] stall_cnt = '0;
    logic [CNT_W-1:0] flush_cnt = '0;

    assign rs_hit = hz.IdUseRs & (hz.IdRs == hz.ExDst);
    assign rt_hit = hz.IdUseRt & (hz.IdRt == hz.ExDst);

    assign load_use = hz.ExMemRead & hz.ExRegWrite
                    & (hz.ExDst != REG_ZERO)
                    & (rs_hit | rt_hit);

    assign div_haz = hz.IdHiLoUse
                   & (div_busy | hz.ExMultiStart);
    assign sad_haz = hz.IdSad & sad_busy;

    assign stall = (load_use | div_haz | sad_haz)
                 & ~hz.ExBranchTaken;

    assign sad_issue = hz.IdSad & ~stall
                     & ~hz.ExBranchTaken;

    busy_timer #(
        .LAT (DIV_LAT)
    ) u_div_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (hz.ExMultiStart),
        .busy  (div_busy)
    );

    // SAD occupancy excludes the issue cycle itself.
    busy_timer #(
        .LAT (SAD_LAT - 1)
    ) u_sad_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (sad_issue),
        .busy  (sad_busy)
    );

    always_comb begin
        ctrl = '0;
        if (Reset) begin
            ctrl = '0;
        end else if (hz.ExBranchTaken) begin
            ctrl = '{1'b1, 1'b1, 1'b1, 1'b1};
        end else if (stall) begin
            ctrl = '{1'b0, 1'b0, 1'b0, 1'b1};
        end else begin
            ctrl = '{1'b1, 1'b1, 1'b0, 1'b0};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.ExBranchTaken && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.PCWrite    = ctrl.PCWrite;
    assign hz.IfIdWrite  = ctrl.IfIdWrite;
    assign hz.IfIdFlush  = ctrl.IfIdFlush;
    assign hz.IdExFlush  = ctrl.IdExFlush;
    assign hz.Busy       = ~Reset & (div_busy | sad_busy);
    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with DIV_LAT=4, SAD_LAT=4, CNT_W=2.
// Control is sampled on the falling edge; inputs change 1ns after rising.
module tb_hazard_stall_ctrl;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    hazard_stall_ctrl_if #(.CNT_W(2)) hz();

    hazard_stall_ctrl #(
        .DIV_LAT (4),
        .SAD_LAT (4),
        .CNT_W   (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hz)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hz.IdRs          = '0;
        hz.IdRt          = '0;
        hz.IdUseRs       = 1'b0;
        hz.IdUseRt       = 1'b0;
        hz.IdHiLoUse     = 1'b0;
        hz.IdSad         = 1'b0;
        hz.ExMemRead     = 1'b0;
        hz.ExRegWrite    = 1'b0;
        hz.ExDst         = '0;
        hz.ExBranchTaken = 1'b0;
        hz.ExMultiStart  = 1'b0;
    endtask

    task automatic load_use_r8();
        hz.ExMemRead  = 1'b1;
        hz.ExRegWrite = 1'b1;
        hz.ExDst      = 5'd8;
        hz.IdRs       = 5'd8;
        hz.IdUseRs    = 1'b1;
    endtask

    // ctrl order: {PCWrite, IfIdWrite, IfIdFlush, IdExFlush}
    task automatic step(input string tag,
                        input logic [3:0] ec,
                        input logic eb);
        @(negedge Clk);
        check({tag, "_ctrl"},
              {28'd0, hz.PCWrite, hz.IfIdWrite,
               hz.IfIdFlush, hz.IdExFlush},
              {28'd0, ec});
        check({tag, "_busy"}, {31'd0, hz.Busy}, {31'd0, eb});
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        step("rst", 4'b0000, 1'b0);
        Reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        Reset = 1'b1;

        // Reset forces outputs low and ignores ExMultiStart.
        load_use_r8();
        hz.IdHiLoUse    = 1'b1;
        hz.ExMultiStart = 1'b1;
        step("rst0", 4'b0000, 1'b0);
        check("rst_stall", 32'(hz.StallCount), 32'd0);
        check("rst_flush", 32'(hz.FlushCount), 32'd0);
        step("rst1", 4'b0000, 1'b0);
        Reset = 1'b0;
        idle();
        step("post_rst", 4'b1100, 1'b0);

        // Load-use on rs: one stall, then normal.
        load_use_r8();
        step("lu", 4'b0001, 1'b0);
        check("lu_cnt", 32'(hz.StallCount), 32'd1);
        idle();
        step("lu_next", 4'b1100, 1'b0);

        // $zero destination never stalls.
        load_use_r8();
        hz.ExDst = 5'd0;
        hz.IdRs  = 5'd0;
        step("zero", 4'b1100, 1'b0);
        check("zero_cnt", 32'(hz.StallCount), 32'd1);

        // Load-use on rt.
        idle();
        load_use_r8();
        hz.IdUseRs = 1'b0;
        hz.IdRt    = 5'd8;
        hz.IdUseRt = 1'b1;
        step("lu_rt", 4'b0001, 1'b0);
        check("lu_rt_cnt", 32'(hz.StallCount), 32'd2);

        // Matching numbers but no actual use.
        hz.IdUseRt = 1'b0;
        step("nouse", 4'b1100, 1'b0);

        // Non-writing EX instruction is not a hazard.
        hz.IdUseRs    = 1'b1;
        hz.ExRegWrite = 1'b0;
        step("nowr", 4'b1100, 1'b0);

        // Taken branch overrides the load-use stall.
        idle();
        load_use_r8();
        hz.ExBranchTaken = 1'b1;
        step("br", 4'b1111, 1'b0);
        check("br_stall", 32'(hz.StallCount), 32'd2);
        check("br_flush", 32'(hz.FlushCount), 32'd1);
        idle();
        hz.ExBranchTaken = 1'b1;
        for (int i = 0; i < 3; i++)
            step("br_sat", 4'b1111, 1'b0);
        check("flush_sat", 32'(hz.FlushCount), 32'd3);

        // Divide: stall at issue cycle plus 4, issue at DivCnt==0.
        do_reset();
        hz.ExMultiStart = 1'b1;
        hz.IdHiLoUse    = 1'b1;
        step("div0", 4'b0001, 1'b0);
        hz.ExMultiStart = 1'b0;
        for (int i = 1; i <= 4; i++)
            step("div_wait", 4'b0001, 1'b1);
        step("div_go", 4'b1100, 1'b0);
        check("stall_sat", 32'(hz.StallCount), 32'd3);

        // Restart at DivCnt=2 reloads to 4.
        do_reset();
        hz.ExMultiStart = 1'b1;
        step("rl0", 4'b1100, 1'b0);
        hz.ExMultiStart = 1'b0;
        step("rl1", 4'b1100, 1'b1);
        step("rl2", 4'b1100, 1'b1);
        hz.ExMultiStart = 1'b1;
        step("rl3", 4'b1100, 1'b1);
        hz.ExMultiStart = 1'b0;
        hz.IdHiLoUse    = 1'b1;
        for (int i = 4; i <= 7; i++)
            step("rl_wait", 4'b0001, 1'b1);
        step("rl_go", 4'b1100, 1'b0);

        // SAD spacing: issues at 0, 4, 8.
        do_reset();
        hz.IdSad = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 4 == 0)
                step("sad_issue", 4'b1100, 1'b0);
            else
                step("sad_hold", 4'b0001, 1'b1);
        end
        check("sad_cnt", 32'(hz.StallCount), 32'd3);

        // Reset at DivCnt=3 discards the divide.
        do_reset();
        hz.ExMultiStart = 1'b1;
        step("md0", 4'b1100, 1'b0);
        hz.ExMultiStart = 1'b0;
        step("md1", 4'b1100, 1'b1);
        hz.IdHiLoUse = 1'b1;
        Reset = 1'b1;
        step("md_rst", 4'b0000, 1'b0);
        Reset = 1'b0;
        step("md_go", 4'b1100, 1'b0);
        check("md_cnt", 32'(hz.StallCount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
